// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM state encodings.
package fft_frame_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fft_frame_ctrl_counter.sv
// Generic enabled counter: steps by 2**LSB, reloads IV after reaching ECV.
module fft_frame_ctrl_counter #(
   parameter int            WL  = 6,
   parameter logic [WL-1:0] IV  = '0,
   parameter int            LSB = 0,
   parameter logic [WL-1:0] ECV = '1
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iCLR,
   input  logic          iEN,
   output logic [WL-1:0] oCNT,
   output logic          oEND
);

   localparam logic [WL-1:0] STEP = {{(WL-1){1'b0}}, 1'b1} << LSB;

   logic [WL-1:0] r_cnt;

   // Count register with synchronous clear and terminal-value reload
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_cnt <= IV;
      end else if (iCLR) begin
         r_cnt <= IV;
      end else if (iEN) begin
         if (r_cnt == ECV) begin
            r_cnt <= IV;
         end else begin
            r_cnt <= r_cnt + STEP;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign oCNT = r_cnt;
   assign oEND = iEN & (r_cnt == ECV);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2 SDF pipeline FFT: input indexing, butterfly
// selects, pipeline fill tracking, output flagging and zero-sample flush.
module fft_frame_ctrl
   import fft_frame_ctrl_pkg::*;
#(
   parameter int LOG2N = 6,
   parameter int LAT   = 66,
   parameter int LW    = 8
) (
   input  logic             iCLK,
   input  logic             iRSTn,
   input  logic             iCLR,
   input  logic             iSTART,
   input  logic             iVALID,
   output logic             oEN,
   output logic             oZERO,
   output logic [LOG2N-1:0] oCNT,
   output logic [LOG2N-1:0] oSEL,
   output logic             oOUT_VALID,
   output logic [LOG2N-1:0] oOUT_IDX,
   output logic             oOUT_SOF,
   output logic             oOUT_EOF,
   output logic             oBUSY,
   output logic             oERR
);

   localparam int               N        = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
   localparam logic [LW-1:0]    LAT_C    = LW'(LAT);
   localparam logic [LW-1:0]    ONE_C    = LW'(1);

   logic [1:0]       r_state;
   logic [LW-1:0]    r_fill;
   logic [LW-1:0]    r_pend;
   logic             r_live;
   logic [1:0]       w_state_nxt;
   logic             w_go, w_start, w_en, w_acc, w_zero, w_out_valid;
   logic             w_cnt_clr, w_cnt_end, w_out_last, w_pend_inc;
   logic [LOG2N-1:0] w_cnt, w_out_idx, w_sel;

   // Outputs stay quiet while in reset, during the first cycle after it, and under clear
   assign w_go    = r_live & ~iCLR;
   assign w_start = w_go & iSTART & iVALID;

   // Per-state datapath enable and sample acceptance
   always_comb begin
      w_en  = 1'b0;
      w_acc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_en  = w_start;
            w_acc = w_start;
         end
         ST_RUN: begin
            w_en  = w_go & iVALID;
            w_acc = w_go & iVALID;
         end
         ST_FLUSH: begin
            w_en  = w_go;
            w_acc = w_start;
         end
         default: begin
            w_en  = 1'b0;
            w_acc = 1'b0;
         end
      endcase
   end

   assign w_zero      = w_go & (r_state == ST_FLUSH) & ~w_start;
   assign w_out_valid = w_en & (r_fill == LAT_C);
   assign w_cnt_clr   = iCLR | ((r_state == ST_IDLE) & ~w_start);
   assign w_pend_inc  = w_start & (r_state != ST_RUN);

   fft_frame_ctrl_counter #(
      .WL(LOG2N), .IV('0), .LSB(0), .ECV(LAST_IDX)
   ) u_in_cnt (
      .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(w_cnt_clr), .iEN(w_acc),
      .oCNT(w_cnt), .oEND(w_cnt_end)
   );

   fft_frame_ctrl_counter #(
      .WL(LOG2N), .IV('0), .LSB(0), .ECV(LAST_IDX)
   ) u_out_cnt (
      .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iEN(w_out_valid),
      .oCNT(w_out_idx), .oEND(w_out_last)
   );

   // Next state; flush only ends on the EOF of the last frame still in flight
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_nxt = ST_RUN;
            else         w_state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (w_cnt_end) w_state_nxt = ST_FLUSH;
            else           w_state_nxt = ST_RUN;
         end
         ST_FLUSH: begin
            if (w_start)                              w_state_nxt = ST_RUN;
            else if (w_out_last && (r_pend == ONE_C)) w_state_nxt = ST_IDLE;
            else                                      w_state_nxt = ST_FLUSH;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, saturating fill level and count of frames not yet fully output
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_state <= ST_IDLE;
         r_fill  <= '0;
         r_pend  <= '0;
      end else if (iCLR) begin
         r_state <= ST_IDLE;
         r_fill  <= '0;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_FLUSH) && (w_state_nxt == ST_IDLE)) begin
            r_fill <= '0;
         end else if (w_en && (r_fill < LAT_C)) begin
            r_fill <= r_fill + ONE_C;
         end else begin
            r_fill <= r_fill;
         end
         r_pend <= r_pend + {{(LW-1){1'b0}}, w_pend_inc} - {{(LW-1){1'b0}}, w_out_last};
      end
   end

   // Marks the controller live one clock after reset release
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) r_live <= 1'b0;
      else        r_live <= 1'b1;
   end

   // Stage s selects on the input index bit that halves its span
   always_comb begin
      w_sel = '0;
      for (int s = 0; s < LOG2N; s++) begin
         w_sel[s] = w_cnt[LOG2N-1-s];
      end
   end

   assign oEN        = w_en;
   assign oZERO      = w_zero;
   assign oCNT       = w_cnt;
   assign oSEL       = w_sel;
   assign oOUT_VALID = w_out_valid;
   assign oOUT_IDX   = w_out_idx;
   assign oOUT_SOF   = w_out_valid & (w_out_idx == '0);
   assign oOUT_EOF   = w_out_valid & (w_out_idx == LAST_IDX);
   assign oBUSY      = (r_state != ST_IDLE);
   assign oERR       = w_start & (r_state == ST_RUN) & (w_cnt != '0);

endmodule
